// File: rtl/mips_mem_access_sequencer.sv
// mips_mem_access_sequencer: multi-cycle load/store/LUI sequencer driving the data-memory req/ack handshake.
// Optional memory watchdog enabled by defining MEM_TIMEOUT_EN.
module mips_mem_access_sequencer #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int TIMEOUT_W      = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [5:0] opcode,
    input  logic       mem_ack,
    output logic       mem_req,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic       luiSign,
    output logic       select2,
    output logic       select1,
    output logic       select0,
    output logic       busy,
    output logic       done,
    output logic       illegal,
    output logic       fault
);
    typedef enum logic [2:0] {IDLE, MEM_RD, MEM_WR, WB, DONE} state_t;

    state_t     state, nxt;
    logic [5:0] op_q;
    logic       to;

    if (2**TIMEOUT_W <= TIMEOUT_CYCLES) begin : g_chk
        $error("TIMEOUT_W too narrow for TIMEOUT_CYCLES");
    end

    function automatic logic is_load(input logic [5:0] op);
        return op inside {6'b100000, 6'b100001, 6'b100011, 6'b100100, 6'b100101};
    endfunction

    function automatic logic is_store(input logic [5:0] op);
        return op inside {6'b101000, 6'b101001, 6'b101011};
    endfunction

    function automatic logic is_lui(input logic [5:0] op);
        return op == 6'b001111;
    endfunction

    function automatic logic [2:0] sel_of(input logic [5:0] op);
        return (op == 6'b100000 || op == 6'b101000) ? 3'b001 :
               (op == 6'b100001 || op == 6'b101001) ? 3'b011 :
               (op == 6'b100100)                    ? 3'b010 :
               (op == 6'b100101)                    ? 3'b100 : 3'b000;
    endfunction

`ifdef MEM_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] wd;
    logic                 fault_q;
    wire                  in_mem = (state == MEM_RD) || (state == MEM_WR);

    assign to = in_mem && !mem_ack && (wd == TIMEOUT_W'(TIMEOUT_CYCLES - 1));

    // Counter sits at zero outside MEM states, so entry always starts a fresh count.
    always_ff @(posedge clk) begin
        if (reset) begin
            wd      <= '0;
            fault_q <= 1'b0;
        end else begin
            wd      <= (in_mem && !mem_ack) ? wd + 1'b1 : '0;
            fault_q <= to;
        end
    end

    assign fault = (state == DONE) && fault_q;
`else
    assign to    = 1'b0;
    assign fault = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            op_q  <= '0;
        end else begin
            state <= nxt;
            if (state == IDLE && start) op_q <= opcode;
        end
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = !start          ? IDLE   :
                           is_load(opcode)  ? MEM_RD :
                           is_store(opcode) ? MEM_WR :
                           is_lui(opcode)   ? WB     : DONE;
            MEM_RD:  nxt = mem_ack ? WB   : to ? DONE : MEM_RD;
            MEM_WR:  nxt = mem_ack ? DONE : to ? DONE : MEM_WR;
            WB:      nxt = DONE;
            default: nxt = IDLE;
        endcase
    end

    always_comb begin
        busy                      = state != IDLE;
        MemRead                   = state == MEM_RD;
        MemWrite                  = state == MEM_WR;
        mem_req                   = MemRead || MemWrite;
        RegWrite                  = state == WB;
        luiSign                   = RegWrite && is_lui(op_q);
        {select2, select1, select0} = busy ? sel_of(op_q) : 3'b000;
        done                      = state == DONE;
        illegal                   = done && !(is_load(op_q) || is_store(op_q) || is_lui(op_q));
    end
endmodule

// File: tb/tb_mips_mem_access_sequencer.sv
// tb_mips_mem_access_sequencer: scoreboard bench; each accepted start pushes its expected completion.
// Define MEM_TIMEOUT_EN to also exercise the watchdog.
module tb_mips_mem_access_sequencer;
    localparam int TC = 16;

    logic       clk = 1'b0;
    logic       reset, start, mem_ack;
    logic [5:0] opcode;
    logic       mem_req, MemRead, MemWrite, RegWrite, luiSign;
    logic       select2, select1, select0, busy, done, illegal, fault;

    mips_mem_access_sequencer #(.TIMEOUT_CYCLES(TC), .TIMEOUT_W(5)) dut (
        .clk(clk), .reset(reset), .start(start), .opcode(opcode), .mem_ack(mem_ack),
        .mem_req(mem_req), .MemRead(MemRead), .MemWrite(MemWrite), .RegWrite(RegWrite),
        .luiSign(luiSign), .select2(select2), .select1(select1), .select0(select0),
        .busy(busy), .done(done), .illegal(illegal), .fault(fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         t0, lat, rd, wr, rw, lui;
        logic [2:0] sel;
        logic       ill, flt;
    } exp_t;

    exp_t q[$];
    exp_t me;
    int   errors = 0, checks = 0, cyc = 0;
    int   n_rd, n_wr, n_rw, n_lui, n_req;
    wire [11:0] outs = {busy, mem_req, MemRead, MemWrite, RegWrite, luiSign,
                        select2, select1, select0, done, illegal, fault};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: per-cycle idle/select checks, transaction comparison on done.
    always @(negedge clk) begin
        if (reset) begin
            n_rd = 0; n_wr = 0; n_rw = 0; n_lui = 0; n_req = 0;
        end else begin
            n_rd += int'(MemRead); n_wr += int'(MemWrite); n_rw += int'(RegWrite);
            n_lui += int'(luiSign); n_req += int'(mem_req);
            if (!busy) check("idle_outs", 32'(outs), 0);
            else if (q.size() > 0) check("select", 32'({select2, select1, select0}), 32'(q[0].sel));
            if (done) begin
                if (q.size() == 0) check("spurious_done", 32'(done), 0);
                else begin
                    me = q.pop_front();
                    check("latency",  32'(cyc - me.t0), 32'(me.lat));
                    check("illegal",  32'(illegal), 32'(me.ill));
                    check("fault",    32'(fault), 32'(me.flt));
                    check("memread",  32'(n_rd), 32'(me.rd));
                    check("memwrite", 32'(n_wr), 32'(me.wr));
                    check("mem_req",  32'(n_req), 32'(me.rd + me.wr));
                    check("regwrite", 32'(n_rw), 32'(me.rw));
                    check("luisign",  32'(n_lui), 32'(me.lui));
                end
                n_rd = 0; n_wr = 0; n_rw = 0; n_lui = 0; n_req = 0;
            end
        end
    end

    function automatic logic [2:0] ref_sel(input logic [5:0] op);
        case (op)
            6'b100000, 6'b101000: return 3'b001;
            6'b100001, 6'b101001: return 3'b011;
            6'b100100:            return 3'b010;
            6'b100101:            return 3'b100;
            default:              return 3'b000;
        endcase
    endfunction

    // d = ack delay in MEM cycles (d<0: never ack); poke = pulse start the cycle after acceptance.
    task automatic go(input logic [5:0] op, input int d, input bit poke);
        exp_t e;
        bit ld, st, lu, tmo;
        ld = op inside {6'b100000, 6'b100001, 6'b100011, 6'b100100, 6'b100101};
        st = op inside {6'b101000, 6'b101001, 6'b101011};
        lu = op == 6'b001111;
        tmo = (ld || st) && d < 0;
        e = '{t0: 0, lat: 1, rd: 0, wr: 0, rw: 0, lui: 0, sel: ref_sel(op),
              ill: !(ld || st || lu), flt: tmo};
        if (tmo) begin
            e.lat = 1 + TC;
            if (ld) e.rd = TC; else e.wr = TC;
        end else if (ld) begin
            e.lat = 3 + d; e.rd = d + 1; e.rw = 1;
        end else if (st) begin
            e.lat = 2 + d; e.wr = d + 1;
        end else if (lu) begin
            e.lat = 2; e.rw = 1; e.lui = 1;
        end
        @(negedge clk);
        start = 1'b1; opcode = op; e.t0 = cyc;
        q.push_back(e);
        for (int i = 1; i <= 80 && q.size() > 0; i++) begin
            @(negedge clk);
            start   = poke && i == 1;
            opcode  = start ? 6'b001111 : 6'b111111;
            mem_ack = (ld || st) ? (d >= 0 && i == d + 1) : (d >= 0);
        end
        start = 1'b0; mem_ack = 1'b0;
        if (q.size() > 0) begin
            check("done_timeout", 0, 1);
            q.delete();
        end
    endtask

    initial begin
        logic [5:0] ops [12];
        ops = '{6'b100000, 6'b100001, 6'b100011, 6'b100100, 6'b100101, 6'b101000,
                6'b101001, 6'b101011, 6'b001111, 6'b000000, 6'b100010, 6'b111111};
        reset = 1'b1; start = 1'b0; opcode = '0; mem_ack = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_outs", 32'(outs), 0);
        reset = 1'b0;
        go(6'b100011, 0, 1'b0);
        go(6'b101001, 3, 1'b0);
        go(6'b001111, 0, 1'b0);
        go(6'b000000, 0, 1'b1);
        go(6'b101001, 1, 1'b1);
        foreach (ops[i]) go(ops[i], int'($urandom_range(0, 3)), 1'(i % 2));
        // Abort a load in its second MEM_RD cycle.
        @(negedge clk);
        start = 1'b1; opcode = 6'b100100;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        q.delete();
        @(negedge clk);
        check("abort_outs", 32'(outs), 0);
        reset = 1'b0;
        repeat (5) @(negedge clk);
`ifdef MEM_TIMEOUT_EN
        go(6'b100011, -1, 1'b0);
        go(6'b101011, -1, 1'b0);
        go(6'b100011, TC - 1, 1'b0);
`endif
        go(6'b100101, 2, 1'b0);
        repeat (3) @(negedge clk);
        check("queue_empty", 32'(q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
